// File: rtl/riscv_pipe_ctrl.sv
// Pipeline hazard controller: memory freeze, multi-cycle mul/div, branch flush,
// load-use interlock and a saturating count of PC-stall cycles.
module riscv_pipe_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned CNT_W         = 32
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ready,
    input  logic        i_muldiv_start,
    input  logic        i_branch_taken,
    input  logic        i_load_use,
    input  logic        i_cnt_clr,
    output logic        o_stall_pc,
    output logic        o_stall_ifid,
    output logic        o_stall_idex,
    output logic        o_stall_exmem,
    output logic        o_stall_memwb,
    output logic        o_flush_ifid,
    output logic        o_flush_idex,
    output logic        o_flush_exmem,
    output logic        o_muldiv_done,
    output logic        o_busy,
    output logic [31:0] o_stall_cnt
);

    typedef enum logic {StRun, StMuldiv} state_e;

    // The start cycle is the first EX cycle, so MULDIV is entered with one cycle already spent.
    localparam bit         SingleCycle = (MULDIV_CYCLES == 1);
    localparam logic [7:0] LoadVal     = (MULDIV_CYCLES >= 2) ? 8'(MULDIV_CYCLES - 2) : 8'd0;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic freeze;
    logic md_stall;
    logic st_pc, st_ifid, st_idex, st_exmem, st_memwb;
    logic fl_ifid, fl_idex, fl_exmem, done;

    assign freeze = i_dmem_req & ~i_dmem_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_stall = 1'b0;
        st_pc    = 1'b0;
        st_ifid  = 1'b0;
        st_idex  = 1'b0;
        st_exmem = 1'b0;
        st_memwb = 1'b0;
        fl_ifid  = 1'b0;
        fl_idex  = 1'b0;
        fl_exmem = 1'b0;
        done     = 1'b0;
        if (freeze) begin
            st_pc    = 1'b1;
            st_ifid  = 1'b1;
            st_idex  = 1'b1;
            st_exmem = 1'b1;
            st_memwb = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (i_muldiv_start) begin
                        if (SingleCycle) begin
                            done = 1'b1;
                        end else begin
                            md_stall = 1'b1;
                            state_d  = StMuldiv;
                            cnt_d    = LoadVal;
                        end
                    end else if (i_branch_taken) begin
                        fl_ifid = 1'b1;
                        fl_idex = 1'b1;
                    end else if (i_load_use) begin
                        st_pc   = 1'b1;
                        st_ifid = 1'b1;
                        fl_idex = 1'b1;
                    end
                end
                StMuldiv: begin
                    if (cnt_q == 8'd0) begin
                        done    = 1'b1;
                        state_d = StRun;
                    end else begin
                        md_stall = 1'b1;
                        cnt_d    = cnt_q - 8'd1;
                    end
                end
                default: state_d = StRun;
            endcase
            if (md_stall) begin
                st_pc    = 1'b1;
                st_ifid  = 1'b1;
                st_idex  = 1'b1;
                fl_exmem = 1'b1;
            end
        end
    end

    // Reset forces every control output low, independent of state.
    assign o_stall_pc    = st_pc & i_rstn;
    assign o_stall_ifid  = st_ifid & i_rstn;
    assign o_stall_idex  = st_idex & i_rstn;
    assign o_stall_exmem = st_exmem & i_rstn;
    assign o_stall_memwb = st_memwb & i_rstn;
    assign o_flush_ifid  = fl_ifid & i_rstn;
    assign o_flush_idex  = fl_idex & i_rstn;
    assign o_flush_exmem = fl_exmem & i_rstn;
    assign o_muldiv_done = done & i_rstn;
    assign o_busy        = (state_q == StMuldiv) & i_rstn;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (st_pc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_stall_cnt = 32'(stall_cnt_q);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= StRun;
            cnt_q       <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
